// File: rtl/co_rotator_param.sv
`default_nettype none
// ============================================================================
// co_rotator_param : carrier-offset rotator, (I+jQ)*exp(+/-j*phase), 3-cycle latency
// Rev 1.0
// ============================================================================
module co_rotator_param #(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 14,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 8,
  parameter int COEF_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [IN_W-1:0]    I,
  input  logic signed [IN_W-1:0]    Q,
  input  logic        [PHASE_W-1:0] freq_word,
  input  logic                      dir,
  input  logic                      bypass,
  input  logic                      phase_clr,
  output logic signed [OUT_W-1:0]   I_ro,
  output logic signed [OUT_W-1:0]   Q_ro,
  output logic                      out_valid
);

  localparam int  LUT_N  = 1 << LUT_AW;
  localparam int  PROD_W = IN_W + COEF_W;
  localparam int  SUM_W  = PROD_W + 1;
  localparam int  AMP    = (1 << (COEF_W - 1)) - 1;
  localparam real PI     = 3.14159265358979323846;

  function automatic real taylor_sin(input real x);
    real term, sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real taylor_cos(input real x);
    real term, sum;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int round_amp(input real x);
    real y;
    y = x * real'(AMP);
    return (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(0.5 - y);
  endfunction

  // Angles are folded into the first quadrant so the table is exactly symmetric.
  function automatic logic [LUT_N*COEF_W-1:0] build_tab(input bit want_sin);
    logic [LUT_N*COEF_W-1:0] tab;
    int  quad, r, cv, sv, v;
    real ang;
    tab = '0;
    for (int k = 0; k < LUT_N; k++) begin
      quad = k / (LUT_N / 4);
      r    = k % (LUT_N / 4);
      ang  = 2.0 * PI * real'(r) / real'(LUT_N);
      cv   = round_amp(taylor_cos(ang));
      sv   = round_amp(taylor_sin(ang));
      case (quad)
        0:       v = want_sin ?  sv :  cv;
        1:       v = want_sin ?  cv : -sv;
        2:       v = want_sin ? -sv : -cv;
        default: v = want_sin ? -cv :  sv;
      endcase
      tab[k*COEF_W +: COEF_W] = v[COEF_W-1:0];
    end
    return tab;
  endfunction

  localparam logic [LUT_N*COEF_W-1:0] COS_TAB = build_tab(1'b0);
  localparam logic [LUT_N*COEF_W-1:0] SIN_TAB = build_tab(1'b1);

  logic signed [COEF_W-1:0] w_cos_tab [LUT_N];
  logic signed [COEF_W-1:0] w_sin_tab [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign w_cos_tab[k] = COS_TAB[k*COEF_W +: COEF_W];
    assign w_sin_tab[k] = SIN_TAB[k*COEF_W +: COEF_W];
  end

  logic [PHASE_W-1:0] acc_q, acc_d, w_p;
  logic               v1_q, v2_q, v3_q;
  logic [LUT_AW-1:0]  addr1_q;
  logic               dir1_q;
  logic [IN_W-1:0]    i1_q, q1_q, i2_q, q2_q;
  logic [COEF_W-1:0]  c2_q, s2_q;
  logic [PROD_W-1:0]  ic_q, qs_q, is_q, qc_q;
  logic [PROD_W-1:0]  w_i_ext, w_q_ext, w_c_ext, w_s_ext;
  logic [SUM_W-1:0]   w_i_sum, w_q_sum;
  logic [OUT_W-1:0]   w_i_out, w_q_out;

  always_comb begin
    w_p   = phase_clr ? '0 : acc_q;
    acc_d = en ? (w_p + freq_word) : w_p;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q     <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      out_valid <= 1'b0;
      I_ro      <= '0;
      Q_ro      <= '0;
    end else begin
      acc_q     <= acc_d;
      v1_q      <= en;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      out_valid <= v3_q;
      if (v3_q) begin
        I_ro <= w_i_out;
        Q_ro <= w_q_out;
      end
    end
  end

  // Operands sign-extended to full product width; low bits of the product are exact.
  assign w_i_ext = {{COEF_W{i2_q[IN_W-1]}}, i2_q};
  assign w_q_ext = {{COEF_W{q2_q[IN_W-1]}}, q2_q};
  assign w_c_ext = {{IN_W{c2_q[COEF_W-1]}}, c2_q};
  assign w_s_ext = {{IN_W{s2_q[COEF_W-1]}}, s2_q};

  always_ff @(posedge clk) begin
    if (en) begin
      addr1_q <= bypass ? '0 : w_p[PHASE_W-1 -: LUT_AW];
      dir1_q  <= dir;
      i1_q    <= I;
      q1_q    <= Q;
    end
    if (v1_q) begin
      c2_q <= w_cos_tab[addr1_q];
      s2_q <= dir1_q ? -w_sin_tab[addr1_q] : w_sin_tab[addr1_q];
      i2_q <= i1_q;
      q2_q <= q1_q;
    end
    if (v2_q) begin
      ic_q <= w_i_ext * w_c_ext;
      qs_q <= w_q_ext * w_s_ext;
      is_q <= w_i_ext * w_s_ext;
      qc_q <= w_q_ext * w_c_ext;
    end
  end

  assign w_i_sum = {ic_q[PROD_W-1], ic_q} - {qs_q[PROD_W-1], qs_q};
  assign w_q_sum = {is_q[PROD_W-1], is_q} + {qc_q[PROD_W-1], qc_q};

  if (SUM_W < OUT_W) begin : g_sext
    assign w_i_out = {{(OUT_W-SUM_W){w_i_sum[SUM_W-1]}}, w_i_sum};
    assign w_q_out = {{(OUT_W-SUM_W){w_q_sum[SUM_W-1]}}, w_q_sum};
  end else if (SUM_W == OUT_W) begin : g_pass
    assign w_i_out = w_i_sum;
    assign w_q_out = w_q_sum;
  end else begin : g_sat
    function automatic logic [OUT_W-1:0] sat(input logic [SUM_W-1:0] v);
      if ((&v[SUM_W-1:OUT_W-1]) || !(|v[SUM_W-1:OUT_W-1]))
        sat = v[OUT_W-1:0];
      else if (v[SUM_W-1])
        sat = {1'b1, {(OUT_W-1){1'b0}}};
      else
        sat = {1'b0, {(OUT_W-1){1'b1}}};
    endfunction
    assign w_i_out = sat(w_i_sum);
    assign w_q_out = sat(w_q_sum);
  end

endmodule
`default_nettype wire

// File: tb/tb_co_rotator_param.sv
`default_nettype none
// tb_co_rotator_param : directed + random stimulus against a trigonometric reference model.
module tb_co_rotator_param;

  localparam int  IN_W    = 2;
  localparam int  OUT_W   = 14;
  localparam int  PHASE_W = 16;
  localparam int  LUT_AW  = 8;
  localparam int  COEF_W  = 12;
  localparam real PI      = 3.14159265358979323846;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic signed [IN_W-1:0]    I;
  logic signed [IN_W-1:0]    Q;
  logic        [PHASE_W-1:0] freq_word;
  logic                      dir;
  logic                      bypass;
  logic                      phase_clr;
  logic signed [OUT_W-1:0]   I_ro;
  logic signed [OUT_W-1:0]   Q_ro;
  logic                      out_valid;

  co_rotator_param #(
    .IN_W(IN_W), .OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .COEF_W(COEF_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .I(I), .Q(Q), .freq_word(freq_word),
    .dir(dir), .bypass(bypass), .phase_clr(phase_clr),
    .I_ro(I_ro), .Q_ro(Q_ro), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int due; bit v; int i; int q; } ent_t;

  ent_t pend[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc    = 0;
  int   exp_i  = 0;
  int   exp_q  = 0;
  int   exp_v  = 0;

  function automatic int rnd(input real y);
    return (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(0.5 - y);
  endfunction

  function automatic int amp();
    return (1 << (COEF_W - 1)) - 1;
  endfunction

  function automatic int coef_c(input int k);
    return rnd(real'(amp()) * $cos(2.0 * PI * real'(k) / real'(1 << LUT_AW)));
  endfunction

  function automatic int coef_s(input int k);
    return rnd(real'(amp()) * $sin(2.0 * PI * real'(k) / real'(1 << LUT_AW)));
  endfunction

  function automatic int clamp(input int x);
    int hi, lo;
    hi = (1 << (OUT_W - 1)) - 1;
    lo = -(1 << (OUT_W - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then check outputs.
  task automatic step(input string tag, input bit r, input bit e, input int ii, input int qq,
                      input int fw, input bit d, input bit b, input bit c);
    int   p, k, cc, ss, sp;
    ent_t h;
    rst       = r;
    en        = e;
    I         = ii[IN_W-1:0];
    Q         = qq[IN_W-1:0];
    freq_word = fw[PHASE_W-1:0];
    dir       = d;
    bypass    = b;
    phase_clr = c;
    @(posedge clk);
    cyc++;
    if (!r) begin
      acc = 0;
      pend.delete();
      exp_v = 0;
      exp_i = 0;
      exp_q = 0;
    end else begin
      p = c ? 0 : acc;
      if (e) begin
        k  = b ? 0 : p / (1 << (PHASE_W - LUT_AW));
        cc = coef_c(k);
        ss = coef_s(k);
        sp = d ? -ss : ss;
        pend.push_back(ent_t'{cyc + 3, 1'b1, clamp(ii * cc - qq * sp), clamp(ii * sp + qq * cc)});
        acc = (p + fw) % (1 << PHASE_W);
      end else begin
        pend.push_back(ent_t'{cyc + 3, 1'b0, 0, 0});
        acc = p;
      end
      exp_v = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        h = pend.pop_front();
        if (h.v) begin
          exp_v = 1;
          exp_i = h.i;
          exp_q = h.q;
        end
      end
    end
    #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, exp_v);
    chk({tag, "_I"}, 32'(I_ro), exp_i);
    chk({tag, "_Q"}, 32'(Q_ro), exp_q);
  endtask

  task automatic idle(input string tag, input int n);
    for (int j = 0; j < n; j++) step(tag, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; I = '0; Q = '0;
    freq_word = '0; dir = 1'b0; bypass = 1'b0; phase_clr = 1'b0;

    for (int j = 0; j < 3; j++) step("reset", 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // phase zero and bypass
    step("ph0", 1'b1, 1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    step("byp", 1'b1, 1'b1, -2, 1, 'h1234, 1'b0, 1'b1, 1'b0);
    idle("flush1", 3);
    chk("byp_hold_I", 32'(I_ro), -4094);
    chk("byp_hold_Q", 32'(Q_ro), 2047);

    // quarter-turn rotation, then derotation
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 4; j++)
        step(d ? "derot" : "rot", 1'b1, 1'b1, 1, 0, 'h4000, d[0], 1'b0, j == 0);
      idle("flush2", 3);
      chk(d ? "derot_last_Q" : "rot_last_Q", 32'(Q_ro), d ? 2047 : -2047);
    end

    // bubbles and accumulator wrap
    step("wrap", 1'b1, 1'b1, 1, 0, 'hC000, 1'b0, 1'b0, 1'b1);
    step("wrap", 1'b1, 1'b0, 0, 0, 'hC000, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) step("wrap", 1'b1, 1'b1, 1, 0, 'hC000, 1'b0, 1'b0, 1'b0);
    idle("flush3", 3);
    chk("wrap_last_I", 32'(I_ro), 2047);

    // phase clear on the third sample
    for (int j = 0; j < 4; j++) step("clr", 1'b1, 1'b1, 1, 0, 'h4000, 1'b0, 1'b0, j == 0 || j == 2);
    idle("flush4", 3);
    chk("clr_last_Q", 32'(Q_ro), 2047);

    // reset with samples in flight
    for (int j = 0; j < 3; j++) step("inflight", 1'b1, 1'b1, -1, 1, 'h2345, 1'b0, 1'b0, 1'b0);
    step("midrst", 1'b0, 1'b1, 1, 1, 'h1000, 1'b0, 1'b0, 1'b0);
    step("postrst", 1'b1, 1'b1, 1, 0, 'h0100, 1'b0, 1'b0, 1'b0);
    idle("flush5", 3);
    chk("postrst_I", 32'(I_ro), 2047);
    chk("postrst_Q", 32'(Q_ro), 0);

    // randomized traffic
    for (int j = 0; j < 400; j++) begin
      step("rand",
           $urandom_range(0, 59) != 0,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 3)) - 2,
           int'($urandom_range(0, 3)) - 2,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) * 'h4000
                                       : int'($urandom_range(0, 65535)),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0);
    end
    idle("drain", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/co_rotator_param.md
Name: co_rotator_param

Overview:
Parametrised carrier-offset rotator for the baseband chain. It multiplies each accepted complex sample (I,Q) by exp(±j·phase), where phase advances by a programmable frequency word per accepted sample. This applies or removes a carrier frequency offset. It sits after the symbol mapper (QPSK, 2-bit I/Q by default) and feeds the downstream wide datapath. It adds programmable offset, direction, bypass, phase clear and an output-valid qualifier.

Parameters:
IN_W, 2, input I/Q width, signed two's complement
OUT_W, 14, output I/Q width, signed
PHASE_W, 16, phase accumulator / freq_word width (2^PHASE_W = one full turn)
LUT_AW, 8, sin/cos table address width (2^LUT_AW entries per full turn)
COEF_W, 12, signed sin/cos coefficient width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
en  in  1  input sample valid; I/Q accepted on a rising edge with en=1
I  in  IN_W  input in-phase sample, signed
Q  in  IN_W  input quadrature sample, signed
freq_word  in  PHASE_W  phase increment per accepted sample, unsigned
dir  in  1  0: rotate by +phase; 1: rotate by -phase (derotate)
bypass  in  1  1: force phase 0 for this sample (unity gain, no rotation)
phase_clr  in  1  synchronous clear of the phase accumulator
I_ro  out  OUT_W  rotated in-phase output, signed
Q_ro  out  OUT_W  rotated quadrature output, signed
out_valid  out  1  I_ro/Q_ro carry a new result this cycle

Behaviour:
- Reset (rst=0 at a rising edge): acc=0, all pipeline valids=0, I_ro=0, Q_ro=0, out_valid=0. Reset overrides en and phase_clr. In-flight samples are discarded.
- Phase of an accepted sample: p = (phase_clr ? 0 : acc).
- Accumulator update at the acceptance edge: acc <= p + freq_word, mod 2^PHASE_W (natural wrap).
- With en=0: acc holds, or becomes 0 if phase_clr=1.
- If bypass=1 on an accepted sample, that sample uses address 0, but acc still advances.
- freq_word, dir and bypass are sampled with the sample they accompany. Changes affect only samples accepted afterwards.
- LUT address: addr = p[PHASE_W-1 -: LUT_AW] (truncate, no dither).
- LUT contents: c[k] = round(A·cos(2πk/2^LUT_AW)) and s[k] = round(A·sin(2πk/2^LUT_AW)), with A = 2^(COEF_W-1)-1 = 2047 by default. The table is synthesisable constant logic (full-wave or quarter-wave with symmetry; results must be identical).
- Arithmetic, full precision with no rounding; s' = dir ? -s : s:
  - I_ro = I·c - Q·s'
  - Q_ro = I·s' + Q·c
  - Internal sum width: IN_W+COEF_W+1.
- Output sizing:
  - If IN_W+COEF_W+1 <= OUT_W: sign-extend.
  - Otherwise: saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Default case: max magnitude 8188, so no saturation.
- Latency: a fixed 3 cycles. A sample accepted at edge k updates I_ro, Q_ro and out_valid=1 at edge k+3.
- Throughput: one sample per cycle.
- Bubbles: en=0 at edge k gives out_valid=0 after edge k+3, and I_ro/Q_ro hold their last value.
- Simultaneous phase_clr and en: that sample uses phase 0, and acc becomes freq_word.
- Reset released mid-stream: the first sample accepted after release uses phase 0.

Test Plan:
1. Phase 0 / bypass:
   - freq_word=0, I=01 (+1), Q=00 → I_ro=2047, Q_ro=0, out_valid 3 cycles after acceptance.
   - bypass=1, freq_word=0x1234, I=10 (-2), Q=01 → I_ro=-4094, Q_ro=2047.
2. Quarter-turn rotation: freq_word=0x4000, dir=0, I=+1, Q=0 for 4 consecutive samples → (2047,0), (0,2047), (-2047,0), (0,-2047) on 4 consecutive cycles.
3. Derotation: same as scenario 2 with dir=1 → (2047,0), (0,-2047), (-2047,0), (0,2047). Feeding the scenario-2 outputs back through a dir=1 reference model returns the input ×2047.
4. Bubbles and wrap: freq_word=0xC000, en pattern 1,0,1,1,1,1 → out_valid pattern 1,0,1,1,1,1 delayed by 3. Phases 0, 270°, 180°, 90°, 0° (acc wraps). Outputs hold during the bubble.
5. phase_clr: freq_word=0x4000, phase_clr=1 together with the 3rd accepted sample → that sample's output is (2047,0), and the next is (0,2047).
6. Reset mid-operation: rst=0 for 1 cycle with 3 samples in flight → after that edge, out_valid=0 and I_ro=Q_ro=0. No stale outputs appear afterward. The first post-reset sample (I=+1, Q=0) gives (2047,0).
